// File: rtl/arrow_pkg.sv
// arrow_pkg: shared definitions for the arrow motion block.
//   CORDW_DEF / ARROW_COUNT_DEF / PARK_Y_DEF : default geometry.
//   coord_t        : default-width screen coordinate.
//   motion_state_t : per-frame update sequencer states.
//   lane_lsb/lane_bit : map a lane index onto the MSB-first packed buses
//                       (lane 0 occupies the most significant slice/bit).
package arrow_pkg;

    localparam int CORDW_DEF       = 10;
    localparam int ARROW_COUNT_DEF = 4;
    localparam int PARK_Y_DEF      = 1023;

    typedef logic [CORDW_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } motion_state_t;

    // Low bit of lane's slice in a bus of count slices, each width wide.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned count,
                                             input int unsigned width);
        return (count - 1 - lane) * width;
    endfunction

    // Bit position of lane in a count-wide per-lane flag vector.
    function automatic int unsigned lane_bit(input int unsigned lane,
                                             input int unsigned count);
        return count - 1 - lane;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: per-lane button synchronizer and rising-edge detector.
//   clk_i  : pixel clock
//   rst_i  : synchronous active-high reset
//   btn_i  : raw asynchronous buttons, one bit per lane
//   rise_o : one-cycle pulse on each synchronized 0->1 transition
module btn_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/arrow_motion.sv
// arrow_motion: spawns, scrolls and judges one arrow per lane.
//   clk_i, rst_i      : pixel clock, synchronous active-high reset
//   frame_i           : frame-start pulse; starts a scroll pass in IDLE
//   spawn_valid_i/spawn_lanes_i/spawn_ready_o : spawn handshake
//   btn_i             : raw lane buttons (lane 0 = MSB)
//   arrow_y_o         : packed lane Y (lane 0 in MSB slice), PARK_Y if idle
//   arrow_active_o    : lane-active flags (lane 0 = MSB)
//   hit_o / miss_o    : one-cycle judge pulses
//   hit_cnt_o / miss_cnt_o : saturating counters
// Optional macro ARROW_COMBO_EN adds combo_o and max_combo_o.
module arrow_motion
    import arrow_pkg::*;
#(
    parameter int CORDW       = CORDW_DEF,
    parameter int ARROW_COUNT = ARROW_COUNT_DEF,
    parameter int SPAWN_Y     = 480,
    parameter int PARK_Y      = PARK_Y_DEF,
    parameter int TARGET_Y    = 40,
    parameter int HIT_WIN     = 8,
    parameter int SPEED       = 2,
    parameter int SCOREW      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_i,
    input  logic                         spawn_valid_i,
    input  logic [ARROW_COUNT-1:0]       spawn_lanes_i,
    output logic                         spawn_ready_o,
    input  logic [ARROW_COUNT-1:0]       btn_i,
    output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
    output logic [ARROW_COUNT-1:0]       arrow_active_o,
    output logic                         hit_o,
    output logic                         miss_o,
    output logic [SCOREW-1:0]            hit_cnt_o,
    output logic [SCOREW-1:0]            miss_cnt_o
`ifdef ARROW_COMBO_EN
   ,output logic [SCOREW-1:0]            combo_o,
    output logic [SCOREW-1:0]            max_combo_o
`endif
);

    localparam int YW     = CORDW * ARROW_COUNT;
    localparam int IDXW   = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1;
    localparam int WLO_I  = (TARGET_Y > HIT_WIN) ? (TARGET_Y - HIT_WIN) : 0;
    localparam int WHI_I  = TARGET_Y + HIT_WIN;

    localparam logic [CORDW-1:0] SPAWN_C  = SPAWN_Y[CORDW-1:0];
    localparam logic [CORDW-1:0] PARK_C   = PARK_Y[CORDW-1:0];
    localparam logic [CORDW-1:0] SPEED_C  = SPEED[CORDW-1:0];
    localparam logic [CORDW-1:0] WIN_LO_C = WLO_I[CORDW-1:0];
    localparam logic [CORDW-1:0] WIN_HI_C = WHI_I[CORDW-1:0];
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(ARROW_COUNT - 1);

    function automatic logic [SCOREW-1:0] sat_add(input logic [SCOREW-1:0] a,
                                                  input logic [SCOREW-1:0] b);
        logic [SCOREW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCOREW] ? '1 : s[SCOREW-1:0];
    endfunction

    motion_state_t          state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [YW-1:0]          y_q, y_d;
    logic [ARROW_COUNT-1:0] active_q, active_d;
    logic [ARROW_COUNT-1:0] pend_q, pend_d;
    logic                   ready_q, ready_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic [SCOREW-1:0]      hit_cnt_q, hit_cnt_d;
    logic [SCOREW-1:0]      miss_cnt_q, miss_cnt_d;
`ifdef ARROW_COMBO_EN
    logic [SCOREW-1:0]      combo_q, combo_d;
    logic [SCOREW-1:0]      max_combo_q, max_combo_d;
`endif

    logic [ARROW_COUNT-1:0] btn_rise;
    logic [CORDW-1:0]       lane_y;
    logic [SCOREW-1:0]      n_hits;

    btn_edge #(
        .WIDTH(ARROW_COUNT)
    ) u_btn_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_i),
        .rise_o(btn_rise)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        y_d        = y_q;
        active_d   = active_q;
        pend_d     = pend_q | btn_rise;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        lane_y     = '0;
        n_hits     = '0;
`ifdef ARROW_COMBO_EN
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
`endif

        case (state_q)
            IDLE: begin
                // Judge every pending lane at once; edges arriving this
                // same cycle survive into the next pending set.
                if (pend_q != '0) begin
                    for (int unsigned i = 0; i < ARROW_COUNT; i++) begin
                        lane_y = y_q[lane_lsb(i, ARROW_COUNT, CORDW) +: CORDW];
                        if (pend_q[lane_bit(i, ARROW_COUNT)] &&
                            active_q[lane_bit(i, ARROW_COUNT)] &&
                            (lane_y >= WIN_LO_C) && (lane_y <= WIN_HI_C)) begin
                            active_d[lane_bit(i, ARROW_COUNT)] = 1'b0;
                            y_d[lane_lsb(i, ARROW_COUNT, CORDW) +: CORDW] = PARK_C;
                            n_hits = n_hits + SCOREW'(1);
                        end
                    end
                    pend_d    = btn_rise;
                    hit_d     = (n_hits != '0);
                    hit_cnt_d = sat_add(hit_cnt_q, n_hits);
`ifdef ARROW_COMBO_EN
                    combo_d = sat_add(combo_q, n_hits);
`endif
                end
                // ready_q already implies nothing is pending, so a spawn
                // never touches the same cycle's judged lanes.
                if (spawn_valid_i && ready_q) begin
                    for (int unsigned i = 0; i < ARROW_COUNT; i++) begin
                        if (spawn_lanes_i[lane_bit(i, ARROW_COUNT)] &&
                            !active_q[lane_bit(i, ARROW_COUNT)]) begin
                            active_d[lane_bit(i, ARROW_COUNT)] = 1'b1;
                            y_d[lane_lsb(i, ARROW_COUNT, CORDW) +: CORDW] = SPAWN_C;
                        end
                    end
                end
                if (frame_i) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end

            UPDATE: begin
                lane_y = y_q[lane_lsb(int'(idx_q), ARROW_COUNT, CORDW) +: CORDW];
                if (active_q[lane_bit(int'(idx_q), ARROW_COUNT)]) begin
                    if (lane_y < SPEED_C) begin
                        active_d[lane_bit(int'(idx_q), ARROW_COUNT)] = 1'b0;
                        y_d[lane_lsb(int'(idx_q), ARROW_COUNT, CORDW) +: CORDW] = PARK_C;
                        miss_d     = 1'b1;
                        miss_cnt_d = sat_add(miss_cnt_q, SCOREW'(1));
`ifdef ARROW_COMBO_EN
                        combo_d = '0;
`endif
                    end else begin
                        y_d[lane_lsb(int'(idx_q), ARROW_COUNT, CORDW) +: CORDW] = lane_y - SPEED_C;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ARROW_COMBO_EN
        if (combo_d > max_combo_q) begin
            max_combo_d = combo_d;
        end
`endif
        ready_d = (state_d == IDLE) && (pend_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            y_q        <= {ARROW_COUNT{PARK_C}};
            active_q   <= '0;
            pend_q     <= '0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`ifdef ARROW_COMBO_EN
            combo_q     <= '0;
            max_combo_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            y_q        <= y_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`ifdef ARROW_COMBO_EN
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
`endif
        end
    end

    assign spawn_ready_o  = ready_q;
    assign arrow_y_o      = y_q;
    assign arrow_active_o = active_q;
    assign hit_o          = hit_q;
    assign miss_o         = miss_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;
`ifdef ARROW_COMBO_EN
    assign combo_o        = combo_q;
    assign max_combo_o    = max_combo_q;
`endif

endmodule

// File: tb/tb_arrow_motion.sv
// tb_arrow_motion: directed bench for arrow_motion with a hit/miss
// scoreboard. Stimulus pushes expected judge events; a monitor pops one
// per hit_o/miss_o pulse and compares the kind and the counter value.
module tb_arrow_motion;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic        spawn_valid;
    logic [3:0]  spawn_lanes;
    logic        spawn_ready;
    logic [3:0]  btn;
    logic [39:0] arrow_y;
    logic [3:0]  arrow_active;
    logic        hit;
    logic        miss;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`ifdef ARROW_COMBO_EN
    logic [15:0] combo;
    logic [15:0] max_combo;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit is_hit;
        int cnt;
    } ev_t;
    ev_t exp_q[$];

    arrow_motion dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_i       (frame),
        .spawn_valid_i (spawn_valid),
        .spawn_lanes_i (spawn_lanes),
        .spawn_ready_o (spawn_ready),
        .btn_i         (btn),
        .arrow_y_o     (arrow_y),
        .arrow_active_o(arrow_active),
        .hit_o         (hit),
        .miss_o        (miss),
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt)
`ifdef ARROW_COMBO_EN
       ,.combo_o       (combo),
        .max_combo_o   (max_combo)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int lane_y(input int lane);
        logic [39:0] v;
        v = arrow_y;
        return int'(v[(3 - lane) * 10 +: 10]);
    endfunction

    task automatic push_ev(input bit is_hit, input int cnt);
        ev_t e;
        e.is_hit = is_hit;
        e.cnt    = cnt;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input bit is_hit, input int cnt);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_event got %s cnt=%0d exp=no event", is_hit ? "hit" : "miss", cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.is_hit != is_hit || e.cnt != cnt) begin
                bad++;
                $display("FAIL sb_event got %s cnt=%0d exp=%s cnt=%0d",
                         is_hit ? "hit" : "miss", cnt, e.is_hit ? "hit" : "miss", e.cnt);
            end
        end
    endtask

    // Monitor: every judge pulse consumes one expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (hit)  sb_pop(1'b1, int'(hit_cnt));
            if (miss) sb_pop(1'b0, int'(miss_cnt));
        end
    end

    task automatic do_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic do_spawn(input logic [3:0] mask);
        bit ok;
        ok          = 1'b0;
        spawn_lanes = mask;
        spawn_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (spawn_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("spawn_handshake_done", 64'(ok), 64'd1);
        @(negedge clk);
        spawn_valid = 1'b0;
        spawn_lanes = 4'b0000;
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        frame       = 1'b0;
        spawn_valid = 1'b0;
        spawn_lanes = 4'b0000;
        btn         = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_ready_low", 64'(spawn_ready), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_y", 64'(arrow_y), 64'({4{10'd1023}}));
        check("rst_active", 64'(arrow_active), 64'd0);
        check("rst_ready", 64'(spawn_ready), 64'd1);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        check("rst_pulses", 64'({hit, miss}), 64'd0);

        // Spawn lane 0 and one scroll step
        do_spawn(4'b1000);
        check("spawn0_y", 64'(lane_y(0)), 64'd480);
        check("spawn0_others", 64'(arrow_y[29:0]), 64'({3{10'd1023}}));
        check("spawn0_active", 64'(arrow_active), 64'b1000);
        do_frame();
        check("frame1_y0", 64'(lane_y(0)), 64'd478);
        check("frame1_y3", 64'(lane_y(3)), 64'd1023);

        // Scroll to the top, then off the top -> miss
        run_frames(239);
        check("top_y0", 64'(lane_y(0)), 64'd0);
        check("top_active", 64'(arrow_active), 64'b1000);
        push_ev(1'b0, 1);
        do_frame();
        check("miss_y0", 64'(lane_y(0)), 64'd1023);
        check("miss_active", 64'(arrow_active), 64'd0);
        check("miss_cnt1", 64'(miss_cnt), 64'd1);

        // Lane 2 hit at y=44
        do_spawn(4'b0010);
        run_frames(218);
        check("pre_hit_y2", 64'(lane_y(2)), 64'd44);
        push_ev(1'b1, 1);
        press(4'b0010);
        check("hit_cnt1", 64'(hit_cnt), 64'd1);
        check("hit_y2", 64'(lane_y(2)), 64'd1023);
        check("hit_active", 64'(arrow_active), 64'd0);

        // Lane 1 press at y=60: outside the window, no effect
        do_spawn(4'b0100);
        run_frames(210);
        check("oow_y1_before", 64'(lane_y(1)), 64'd60);
        press(4'b0100);
        check("oow_active", 64'(arrow_active), 64'b0100);
        check("oow_y1", 64'(lane_y(1)), 64'd60);
        check("oow_cnts", 64'({hit_cnt, miss_cnt}), 64'({16'd1, 16'd1}));

        // Spawn including an already-active lane
        do_spawn(4'b0110);
        check("dup_y1", 64'(lane_y(1)), 64'd60);
        check("dup_y2", 64'(lane_y(2)), 64'd480);
        check("dup_active", 64'(arrow_active), 64'b0110);

        // Spawn held during UPDATE waits for IDLE
        frame = 1'b1;
        @(negedge clk);
        frame       = 1'b0;
        spawn_lanes = 4'b1000;
        spawn_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("upd_ready_low", 64'(spawn_ready), 64'd0);
            @(negedge clk);
        end
        check("upd_ready_back", 64'(spawn_ready), 64'd1);
        check("upd_no_early_spawn", 64'(arrow_active), 64'b0110);
        @(negedge clk);
        spawn_valid = 1'b0;
        spawn_lanes = 4'b0000;
        check("upd_spawn_y0", 64'(lane_y(0)), 64'd480);
        check("upd_y1", 64'(lane_y(1)), 64'd58);
        check("upd_y2", 64'(lane_y(2)), 64'd478);
        check("upd_active", 64'(arrow_active), 64'b1110);

        // Frame pulse during UPDATE is dropped
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (4) @(negedge clk);
        check("ign_ready", 64'(spawn_ready), 64'd1);
        repeat (2) @(negedge clk);
        check("ign_y0", 64'(lane_y(0)), 64'd478);
        check("ign_y1", 64'(lane_y(1)), 64'd56);
        check("ign_y2", 64'(lane_y(2)), 64'd476);

        // Upper window edge: y=48 hits
        run_frames(4);
        check("edge_hi_y1", 64'(lane_y(1)), 64'd48);
        push_ev(1'b1, 2);
        press(4'b0100);
        check("edge_hi_cnt", 64'(hit_cnt), 64'd2);
        check("edge_hi_active", 64'(arrow_active), 64'b1010);

        // Lower edge: lane 0 at 32 hits, lane 2 at 30 is discarded
        run_frames(219);
        check("edge_lo_y0", 64'(lane_y(0)), 64'd32);
        check("edge_lo_y2", 64'(lane_y(2)), 64'd30);
        push_ev(1'b1, 3);
        press(4'b1010);
        check("edge_lo_cnt", 64'(hit_cnt), 64'd3);
        check("edge_lo_active", 64'(arrow_active), 64'b0010);
        check("edge_lo_y2_kept", 64'(lane_y(2)), 64'd30);

        // Lane 2 runs off the top
        run_frames(15);
        push_ev(1'b0, 2);
        do_frame();
        check("miss2_cnt", 64'(miss_cnt), 64'd2);
        check("miss2_y", 64'(arrow_y), 64'({4{10'd1023}}));
`ifdef ARROW_COMBO_EN
        check("combo", 64'(combo), 64'd0);
        check("max_combo", 64'(max_combo), 64'd3);
`endif
        repeat (5) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of an update pass
        do_spawn(4'b1000);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_y", 64'(arrow_y), 64'({4{10'd1023}}));
        check("midrst_active", 64'(arrow_active), 64'd0);
        check("midrst_cnts", 64'({hit_cnt, miss_cnt}), 64'd0);
        check("midrst_ready", 64'(spawn_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arrow_motion.md
Name: arrow_motion

Overview:
- Generates the packed arrow Y-position bus consumed by the arrow drawer.
- Spawns arrows per lane from a step-pattern handshake and scrolls them upward once per frame.
- Judges button presses against a target window and reports hits and misses.
- Sits between the pattern/sequencer logic and the drawer, in the pixel-clock domain.

Parameters:
- CORDW, 10, coordinate width.
- ARROW_COUNT, 4, number of lanes (one arrow per lane).
- SPAWN_Y, 480, Y loaded on spawn (bottom edge).
- PARK_Y, 1023, Y driven for inactive lanes (off-screen).
- TARGET_Y, 40, centre row of the hit window.
- HIT_WIN, 8, half-width of the hit window in rows.
- SPEED, 2, rows moved per frame.
- SCOREW, 16, width of the hit/miss counters.

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  synchronous active-high reset.
- frame_i  in  1  one-cycle pulse at frame start (vblank).
- spawn_valid_i  in  1  spawn request valid.
- spawn_lanes_i  in  ARROW_COUNT  lanes to spawn; bit ARROW_COUNT-1 = lane 0.
- spawn_ready_o  out  1  spawn accepted when high with valid.
- btn_i  in  ARROW_COUNT  raw lane buttons, asynchronous, same bit order.
- arrow_y_o  out  CORDW*ARROW_COUNT  packed Y; lane 0 in MSB slice.
- arrow_active_o  out  ARROW_COUNT  lane-active flags.
- hit_o  out  1  one-cycle pulse per judged hit.
- miss_o  out  1  one-cycle pulse per missed arrow.
- hit_cnt_o  out  SCOREW  saturating hit count.
- miss_cnt_o  out  SCOREW  saturating miss count.

Behaviour:
- Reset (synchronous, rst_i=1):
  - All lanes inactive; arrow_y_o = all lanes PARK_Y.
  - Counters 0; hit_o/miss_o 0; pending hits cleared.
  - FSM to IDLE; spawn_ready_o 0 during reset, 1 the cycle after.
  - Reset mid-UPDATE abandons the update with no partial writes visible afterwards.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on frame_i.
  - UPDATE visits lane index 0..ARROW_COUNT-1, one lane per cycle.
  - UPDATE -> DONE after the last lane; DONE -> IDLE after one cycle.
  - frame_i outside IDLE is ignored. No frame is queued.
- Lane update (in UPDATE, active lanes only):
  - If y < SPEED: lane goes inactive, y = PARK_Y, miss_o pulses the next cycle, and miss_cnt increments.
  - Otherwise y <= y - SPEED.
  - Inactive lanes are untouched.
  - Subtraction is CORDW-wide and never wraps.
- Spawn handshake:
  - spawn_ready_o = (state==IDLE) && (pending_hits==0).
  - Transfer occurs on valid && ready.
  - Each set bit whose lane is inactive loads y = SPAWN_Y and sets active, visible the next cycle.
  - Set bits for lanes already active are dropped silently. The transfer still completes.
  - valid must hold until ready. Lanes may change only after a transfer.
- Buttons:
  - 2-flop synchronizer, then rising-edge detect.
  - Edges OR into pending_hits at any state.
- Judging (IDLE only):
  - All pending lanes are processed in one cycle, then pending_hits clears.
  - For each pending lane that is active and has |y - TARGET_Y| <= HIT_WIN: lane goes inactive, y = PARK_Y, hit_cnt += 1.
  - hit_o pulses once per judging cycle that contains one or more hits. The count increments by the number of hit lanes.
  - Pending lanes that are inactive or outside the window are discarded, with no penalty.
- Counters saturate at 2^SCOREW-1.
- All outputs are registered. Latency from frame_i to the first lane update is 1 cycle; the full update takes ARROW_COUNT+2 cycles.

Optional Feature:
- Macro ARROW_COMBO_EN.
- When defined, adds these ports:
  - combo_o (SCOREW): consecutive hits since the last miss; increments per hit lane and clears on any miss.
  - max_combo_o (SCOREW): running maximum of combo_o.
  - Both reset to 0 and both saturate.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package arrow_pkg:
  - CORDW_DEF, ARROW_COUNT_DEF, PARK_Y_DEF.
  - typedef coord_t (logic [CORDW-1:0]).
  - enum motion_state_t {IDLE, UPDATE, DONE}.
  - Lane slice helper function (lane index to MSB-first bit offset).
- Sub-module btn_edge: per-lane synchronizer and rising-edge detector, instantiated ARROW_COUNT wide.

Test Plan:
- Reset check: after reset, arrow_y_o = {4{10'd1023}}, arrow_active_o = 0, spawn_ready_o = 1, counters 0.
- Spawn 4'b1000, then one frame_i: lane 0 y = 480 after the transfer and 478 after UPDATE; other lanes stay 1023.
- Run 240 frames after spawning lane 0 (480 -> 0), then one more frame: lane 0 despawns, miss_o pulses once, miss_cnt = 1.
- Hit in window: spawn lane 2, run frames until y = 44, then press btn_i[1]: hit_o pulses once, hit_cnt = 1, lane 2 y = 1023.
- Out-of-window press: with y = 60, press btn_i: no hit, no miss, lane stays active.
- Handshake edge cases:
  - Assert spawn_valid_i during UPDATE: ready stays 0 until IDLE.
  - Spawn an already-active lane: transfer completes and y is unchanged.
  - frame_i during UPDATE is ignored.
